// File: rtl/mole_round_controller.sv
// mole_round_controller: sequences one reaction-game session (gap, draw, lit window, judgement)
// and keeps per-game hit/miss/round counters with registered LED and status outputs.
module mole_round_controller #(
  parameter int NUM_ROUNDS = 10,
  parameter int LIT_CYCLES = 50000000,
  parameter int GAP_CYCLES = 25000000,
  parameter int TIMER_W    = 26,
  parameter int MAX_REDRAW = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [3:0] rnd_in_i,
  input  logic [9:0] btn_i,
  output logic [9:0] led_o,
  output logic [7:0] score_o,
  output logic [7:0] miss_o,
  output logic [7:0] round_o,
  output logic       hit_pulse_o,
  output logic       miss_pulse_o,
  output logic       busy_o,
  output logic       game_over_o
);
  typedef enum logic [2:0] {IDLE, GAP, DRAW, LIT, RESULT, DONE} state_t;
  state_t state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [3:0] target_q, target_d, prev_q, prev_d, rnd_v;
  logic [7:0] redraw_q, redraw_d, score_q, score_d, miss_q, miss_d, round_q, round_d;
  logic [9:0] led_q, led_d;
  logic hit_q, hit_d, missp_q, missp_d, busy_q, busy_d, over_q, over_d;
  logic hit, wrong, tout;
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    target_d = target_q;
    prev_d   = prev_q;
    redraw_d = redraw_q;
    score_d  = score_q;
    miss_d   = miss_q;
    round_d  = round_q;
    hit_d    = 1'b0;
    missp_d  = 1'b0;
    rnd_v    = rnd_in_i > 4'd9 ? rnd_in_i - 4'd10 : rnd_in_i;
    hit      = |(btn_i & (10'd1 << target_q));
    wrong    = |btn_i;
    tout     = timer_q == TIMER_W'(LIT_CYCLES - 1);
    if (abort_i) state_d = IDLE;
    else case (state_q)
      IDLE, DONE: if (start_i) begin
        state_d = GAP;
        timer_d = '0;
        prev_d  = 4'hF;
        score_d = '0;
        miss_d  = '0;
        round_d = '0;
      end
      GAP: if (timer_q == TIMER_W'(GAP_CYCLES - 1)) begin
        timer_d  = '0;
        redraw_d = '0;
        state_d  = DRAW;
      end else timer_d = timer_q + 1'b1;
      // a repeat of the previous target is redrawn a bounded number of times, then accepted
      DRAW: if (rnd_v == prev_q && redraw_q < 8'(MAX_REDRAW)) redraw_d = redraw_q + 8'd1;
      else begin
        target_d = rnd_v;
        state_d  = LIT;
      end
      LIT: begin
        timer_d = timer_q + 1'b1;
        if (hit || wrong || tout) begin
          state_d = RESULT;
          hit_d   = hit;
          missp_d = !hit;
          score_d = score_q + 8'(hit);
          miss_d  = miss_q + 8'(!hit);
          round_d = round_q + 8'd1;
        end
      end
      RESULT: begin
        prev_d  = target_q;
        timer_d = '0;
        state_d = round_q == 8'(NUM_ROUNDS) ? DONE : GAP;
      end
      default: state_d = IDLE;
    endcase
    led_d  = state_d == LIT ? 10'd1 << target_d : 10'd0;
    busy_d = state_d == GAP || state_d == DRAW || state_d == LIT || state_d == RESULT;
    over_d = state_d == DONE;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      target_q <= '0;
      prev_q   <= 4'hF;
      redraw_q <= '0;
      score_q  <= '0;
      miss_q   <= '0;
      round_q  <= '0;
      led_q    <= '0;
      hit_q    <= 1'b0;
      missp_q  <= 1'b0;
      busy_q   <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      target_q <= target_d;
      prev_q   <= prev_d;
      redraw_q <= redraw_d;
      score_q  <= score_d;
      miss_q   <= miss_d;
      round_q  <= round_d;
      led_q    <= led_d;
      hit_q    <= hit_d;
      missp_q  <= missp_d;
      busy_q   <= busy_d;
      over_q   <= over_d;
    end
  end
  assign led_o        = led_q;
  assign score_o      = score_q;
  assign miss_o       = miss_q;
  assign round_o      = round_q;
  assign hit_pulse_o  = hit_q;
  assign miss_pulse_o = missp_q;
  assign busy_o       = busy_q;
  assign game_over_o  = over_q;
endmodule

// File: tb/tb_mole_round_controller.sv
// tb_mole_round_controller: table-driven and randomized rounds checked against a round-level game model.
module tb_mole_round_controller;
  localparam int NR = 3, LIT = 8, GAP = 4, MR = 3;
  typedef struct {
    logic [3:0] r1, r2;
    int press;
    logic [9:0] b;
    bit sl;
    bit exp_hit;
    int exp_lit;
  } vec_t;
  logic clk = 0, rst_n = 0, start = 0, abort = 0;
  logic [3:0] rnd = 0;
  logic [9:0] btn = 0;
  logic [9:0] led;
  logic [7:0] score, miss, round;
  logic hit_pulse, miss_pulse, busy, game_over;
  int tests = 0, fails = 0;
  int m_score, m_miss, m_round;
  logic [3:0] m_prev;
  mole_round_controller #(.NUM_ROUNDS(NR), .LIT_CYCLES(LIT), .GAP_CYCLES(GAP), .TIMER_W(4), .MAX_REDRAW(MR)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .rnd_in_i(rnd), .btn_i(btn),
    .led_o(led), .score_o(score), .miss_o(miss), .round_o(round), .hit_pulse_o(hit_pulse),
    .miss_pulse_o(miss_pulse), .busy_o(busy), .game_over_o(game_over));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic logic [3:0] fold(input logic [3:0] v);
    return v > 4'd9 ? v - 4'd10 : v;
  endfunction
  task automatic start_game;
    start = 1;
    step;
    start = 0;
    m_score = 0; m_miss = 0; m_round = 0; m_prev = 4'hF;
    chk("start_busy", busy, 1);
    chk("start_score", score, 0);
    chk("start_miss", miss, 0);
    chk("start_round", round, 0);
    chk("start_over", game_over, 0);
  endtask
  // entered on the first GAP cycle; leaves on the cycle after RESULT
  task automatic play_round(input logic [3:0] r1, input logic [3:0] r2, input int press,
                            input logic [9:0] b0, input bit add_tgt, input bit sl,
                            output bit hit_o, output int lit_o);
    logic [3:0] tgt, v;
    logic [9:0] b;
    int dlen, red, w, k;
    bit pressed;
    red = 0; dlen = 0; tgt = 0;
    for (int i = 0; i <= MR && dlen == 0; i++) begin
      v = fold(i == 0 ? r1 : r2);
      if (v == m_prev && red < MR) red++;
      else begin tgt = v; dlen = i + 1; end
    end
    b = b0 | (add_tgt ? 10'd1 << tgt : 10'd0);
    pressed = press >= 0 && press < LIT && b != 0;
    hit_o = pressed && |(b & (10'd1 << tgt));
    lit_o = pressed ? press + 1 : LIT;
    rnd = r1;
    w = 0;
    while (led == 0 && w < 30) begin
      if (w == GAP + 1) rnd = r2;
      step;
      w++;
    end
    chk("gap_draw_cycles", w, GAP + dlen);
    if (led == 0) return;
    k = 0;
    while (led != 0 && k < 20) begin
      chk("led_onehot", led, 10'd1 << tgt);
      if (k == press) btn = b;
      if (k == 1 && sl) start = 1;
      step;
      btn = 0;
      start = 0;
      k++;
    end
    chk("lit_cycles", k, lit_o);
    m_round++;
    if (hit_o) m_score++; else m_miss++;
    m_prev = tgt;
    chk("hit_pulse", hit_pulse, hit_o);
    chk("miss_pulse", miss_pulse, !hit_o);
    chk("score", score, m_score);
    chk("miss", miss, m_miss);
    chk("round", round, m_round);
    chk("result_led", led, 0);
    step;
    chk("pulse_clear", hit_pulse | miss_pulse, 0);
    chk("game_over", game_over, m_round == NR);
    chk("busy_after", busy, m_round != NR);
  endtask
  initial begin
    vec_t tbl [6];
    bit h;
    int l;
    tbl[0] = '{4'd5,  4'd5, 2,  10'b0000100000, 0, 1, 3};
    tbl[1] = '{4'd7,  4'd7, -1, 10'b0000000000, 0, 0, 8};
    tbl[2] = '{4'd7,  4'd7, 7,  10'b0010000000, 0, 1, 8};
    tbl[3] = '{4'd12, 4'd12, 1, 10'b0000100100, 0, 1, 2};
    tbl[4] = '{4'd2,  4'd7, 0,  10'b0000100100, 0, 0, 1};
    tbl[5] = '{4'd15, 4'd15, 4, 10'b0000100000, 1, 1, 5};
    #2;
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_score", score, 0);
    chk("rst_over", game_over, 0);
    #10 rst_n = 1;
    step; step; step;
    chk("idle_busy", busy, 0);
    for (int g = 0; g < 2; g++) begin
      start_game;
      for (int i = 3 * g; i < 3 * g + 3; i++) begin
        play_round(tbl[i].r1, tbl[i].r2, tbl[i].press, tbl[i].b, 1'b0, tbl[i].sl, h, l);
        chk("tbl_hit", h, tbl[i].exp_hit);
        chk("tbl_lit", l, tbl[i].exp_lit);
      end
      chk("final_score", score, 2);
      chk("final_miss", miss, 1);
    end
    for (int g = 0; g < 4; g++) begin
      start_game;
      for (int i = 0; i < NR; i++)
        play_round(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom_range(0, 9) - 1,
                   $urandom_range(0, 3) == 0 ? 10'd0 : 10'($urandom), 1'($urandom_range(0, 1)), 1'b0, h, l);
    end
    start_game;
    play_round(4'd3, 4'd3, 0, 10'b0000001000, 1'b0, 1'b0, h, l);
    abort = 1;
    step;
    abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_score", score, 1);
    chk("abort_led", led, 0);
    step; step; step;
    chk("abort_idle", busy, 0);
    start_game;
    play_round(4'd4, 4'd4, 0, 10'b0000010000, 1'b0, 1'b0, h, l);
    rnd = 4'd6;
    for (int w = 0; w < 30 && led == 0; w++) step;
    step; step;
    chk("pre_reset_led", led, 10'd1 << 6);
    rst_n = 0;
    #1;
    chk("areset_led", led, 0);
    chk("areset_score", score, 0);
    chk("areset_miss", miss, 0);
    chk("areset_round", round, 0);
    chk("areset_busy", busy, 0);
    step; step;
    #2 rst_n = 1;
    step; step; step;
    chk("post_reset_busy", busy, 0);
    chk("post_reset_led", led, 0);
    start_game;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
